// File: rtl/irq_aggregator_pkg.sv
// irq_aggregator_pkg
// Shared constants and helpers for the interrupt aggregator:
//   - Avalon register word addresses (PENDING, ENABLE, MODE, ID)
//   - MAX_SRC: widest supported source vector / register view
//   - ID_VALID_BIT: "any enabled pending" flag position in the ID register
//   - MODE_LEVEL / MODE_EDGE: per-channel MODE bit encodings
//   - helpers: source mask, byte-lane mask, lowest-set-bit index
package irq_aggregator_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_ID      = 2'd3;

    localparam int MAX_SRC      = 32;
    localparam int ID_VALID_BIT = 31;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    // Ones in the low n bit positions; implemented channels only.
    function automatic logic [31:0] src_mask(input int n);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // Expand the four Avalon byteenable bits to a 32-bit lane mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Index of the lowest set bit (lower index = higher priority); 0 if none.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_aggregator_input_conditioner.sv
// irq_input_conditioner
// One interrupt channel front end: synchroniser chain, optional debounce,
// and rising-edge detect on the conditioned value.
// Optional feature macro: IRQ_DEBOUNCE_EN (adds a per-channel stability counter).
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   i_src       - raw asynchronous source
//   o_level     - conditioned level
//   o_rise      - one-cycle pulse when the conditioned level goes 0 -> 1
module irq_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_src,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_synced;
    logic                   w_cond;
    logic                   r_prev;

    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) || (DEBOUNCE_CYCLES < 1)) begin : g_param_check
        $error("irq_input_conditioner: SYNC_STAGES must be 2..4 and DEBOUNCE_CYCLES >= 1");
    end

    // Synchroniser chain for the asynchronous source
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

`ifdef IRQ_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_cond;

    // Debounce: accept a new level only after it has held for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the current level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_cond <= 1'b0;
        end else if (w_synced == r_cond) begin
            r_cnt  <= {CNT_W{1'b0}};
        end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_cond <= w_synced;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1'b1);
        end
    end

    assign w_cond = r_cond;
`else
    assign w_cond = w_synced;
`endif

    // Previous conditioned value for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_cond;
        end
    end

    assign o_level = w_cond;
    assign o_rise  = w_cond & ~r_prev;

endmodule

// File: rtl/irq_aggregator.sv
// irq_aggregator
// Aggregates NUM_SRC asynchronous interrupt sources into one registered IRQ,
// with per-channel edge/level mode, enable mask, W1C pending and a
// lowest-index-wins ID register on an Avalon-MM slave.
// Optional feature macro: IRQ_DEBOUNCE_EN (per-channel debounce in the conditioner).
// Ports:
//   clk, reset                 - system clock, asynchronous active-high reset
//   address, byteenable,
//   writedata, write           - Avalon-MM write side (word addresses 0..3)
//   readdata                   - combinational read data selected by address
//   irq_sources[NUM_SRC-1:0]   - raw sources, bit i = channel i
//   irq                        - registered |(PENDING & ENABLE)
module irq_aggregator
    import irq_aggregator_pkg::*;
#(
    parameter int NUM_SRC         = 15,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         address,
    input  logic [3:0]         byteenable,
    input  logic [31:0]        writedata,
    input  logic               write,
    output logic [31:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_sources,
    output logic               irq
);

    // Registers are kept 32 bits wide; bits at or above NUM_SRC stay 0.
    localparam logic [31:0] SRC_MASK = src_mask(NUM_SRC);

    logic [NUM_SRC-1:0] w_level_n;
    logic [NUM_SRC-1:0] w_rise_n;
    logic [31:0]        w_level;
    logic [31:0]        w_rise;
    logic [31:0]        w_lanes;
    logic [31:0]        w_wbits;
    logic [31:0]        w_w1c;
    logic [31:0]        w_pend_next;
    logic [31:0]        w_hit;
    logic               w_any;
    logic [4:0]         w_id;

    logic [31:0]        r_pending;
    logic [31:0]        r_enable;
    logic [31:0]        r_mode;
    logic               r_irq;

    if ((NUM_SRC < 1) || (NUM_SRC > MAX_SRC)) begin : g_param_check
        $error("irq_aggregator: NUM_SRC must be 1..32");
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_chan
        irq_input_conditioner #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cond (
            .clk     (clk),
            .reset   (reset),
            .i_src   (irq_sources[g]),
            .o_level (w_level_n[g]),
            .o_rise  (w_rise_n[g])
        );
    end

    // Widen the per-channel vectors to the 32-bit register view
    always_comb begin
        w_level                = 32'd0;
        w_rise                 = 32'd0;
        w_level[NUM_SRC-1:0]   = w_level_n;
        w_rise[NUM_SRC-1:0]    = w_rise_n;
    end

    assign w_lanes = lane_mask(byteenable);
    assign w_wbits = writedata & w_lanes & SRC_MASK;

    // Write-one-to-clear request for PENDING
    always_comb begin
        w_w1c = 32'd0;
        if (write && (address == REG_PENDING)) begin
            w_w1c = w_wbits;
        end else begin
            w_w1c = 32'd0;
        end
    end

    // Next PENDING: edge channels latch rises (a rise beats a same-cycle
    // clear), level channels simply track the conditioned level.
    always_comb begin
        w_pend_next = 32'd0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (r_mode[i] == MODE_EDGE) begin
                w_pend_next[i] = (r_pending[i] & ~w_w1c[i]) | w_rise[i];
            end else begin
                w_pend_next[i] = w_level[i];
            end
        end
    end

    // Control/status registers and the IRQ output flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 32'd0;
            r_enable  <= 32'd0;
            r_mode    <= 32'd0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pend_next & SRC_MASK;
            r_irq     <= |(r_pending & r_enable);
            if (write && (address == REG_ENABLE)) begin
                r_enable <= (r_enable & ~w_lanes) | w_wbits;
            end else begin
                r_enable <= r_enable;
            end
            if (write && (address == REG_MODE)) begin
                r_mode <= (r_mode & ~w_lanes) | w_wbits;
            end else begin
                r_mode <= r_mode;
            end
        end
    end

    assign w_hit = r_pending & r_enable;
    assign w_any = |w_hit;
    assign w_id  = lowest_set(w_hit);

    // Read mux
    always_comb begin
        readdata = 32'd0;
        case (address)
            REG_PENDING: readdata = r_pending;
            REG_ENABLE:  readdata = r_enable;
            REG_MODE:    readdata = r_mode;
            REG_ID: begin
                readdata               = 32'd0;
                readdata[ID_VALID_BIT] = w_any;
                readdata[4:0]          = w_id;
            end
            default:     readdata = 32'd0;
        endcase
    end

    assign irq = r_irq;

endmodule
